udp_line_scheduler: RTL and testbench

- Sequences the single UDP transmit path between two camera line sources (cam1, cam2) in the RGMII clock domain.
- Arbitrates ready lines round-robin and launches one UDP packet per granted line (trig + {cam_id,row} index).
- Tracks the packet through the sender's busy window, enforces an inter-packet gap and reports sender stalls.

---
 rtl/udp_line_scheduler.sv | 145 ++++++++++++++
 tb/tb_udp_line_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_line_scheduler.sv
// Round-robin launcher for the shared UDP transmit path between the two camera line sources.
// Follows each packet through the sender busy window, aborts stalled packets and spaces launches.
module udp_line_scheduler #(
    parameter int         GAP           = 64,
    parameter int         START_TIMEOUT = 256,
    parameter int         DONE_TIMEOUT  = 65535,
    parameter logic [4:0] CAM1_ID       = 5'd1,
    parameter logic [4:0] CAM2_ID       = 5'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  req,
    input  logic [10:0] row1,
    input  logic [10:0] row2,
    output logic [1:0]  grant,
    output logic        udp_trig,
    output logic [15:0] udp_index,
    input  logic        udp_busy,
    output logic        timeout_err,
    output logic [15:0] pkt_cnt
);
    localparam int GAP_N = (GAP < 1) ? 1 : GAP;
    localparam int ST_N  = (START_TIMEOUT < 1) ? 1 : START_TIMEOUT;
    localparam int DT_N  = (DONE_TIMEOUT < 1) ? 1 : DONE_TIMEOUT;
    localparam int MAX_A = (GAP_N > ST_N) ? GAP_N : ST_N;
    localparam int MAX_N = (MAX_A > DT_N) ? MAX_A : DT_N;
    localparam int CW    = (MAX_N < 2) ? 1 : $clog2(MAX_N);

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_N - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(ST_N - 1);
    localparam logic [CW-1:0] DT_LAST  = CW'(DT_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_grant;
    logic            r_trig;
    logic [15:0]     r_index;
    logic            r_ptr;
    logic            r_err;
    logic [15:0]     r_pkt_cnt;

    state_t          w_nxt_state;
    logic [CW-1:0]   w_nxt_cnt;
    logic            w_launch;
    logic            w_err;
    logic            w_done;
    logic            w_win2;

    // r_ptr=0 prefers cam1; a lone requester wins regardless of the pointer.
    assign w_win2 = req[1] & (~req[0] | r_ptr);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_launch    = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (|req)) begin
                    w_launch    = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (udp_busy) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_WAIT_DONE;
                end else if (r_cnt == ST_LAST) begin
                    w_err       = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_GAP;
                end else begin
                    w_nxt_cnt   = r_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!udp_busy) begin
                    w_done      = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_GAP;
                end else if (r_cnt == DT_LAST) begin
                    w_err       = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_GAP;
                end else begin
                    w_nxt_cnt   = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_cnt   = '0;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_grant   <= 2'b00;
            r_trig    <= 1'b0;
            r_index   <= 16'd0;
            r_ptr     <= 1'b0;
            r_err     <= 1'b0;
            r_pkt_cnt <= 16'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_trig  <= w_launch;
            r_err   <= w_err;
            r_grant <= w_launch ? (w_win2 ? 2'b10 : 2'b01) : 2'b00;
            // Rows are captured only here; the index then holds until the next launch.
            if (w_launch) begin
                r_index <= w_win2 ? {CAM2_ID, row2} : {CAM1_ID, row1};
                r_ptr   <= ~w_win2;
            end
            if (w_done)
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign grant       = r_grant;
    assign udp_trig    = r_trig;
    assign udp_index   = r_index;
    assign timeout_err = r_err;
    assign pkt_cnt     = r_pkt_cnt;
endmodule

// File: tb/tb_udp_line_scheduler.sv
// Randomized bench for udp_line_scheduler: a sender model drives udp_busy and a rule-level
// model predicts winners, indices, launch cycles, aborts and completion counts.
module tb_udp_line_scheduler;
    localparam int G  = 64;
    localparam int ST = 256;
    localparam int DT = 100;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [1:0]  req;
    logic [10:0] row1;
    logic [10:0] row2;
    logic [1:0]  grant;
    logic        udp_trig;
    logic [15:0] udp_index;
    logic        udp_busy;
    logic        timeout_err;
    logic [15:0] pkt_cnt;

    udp_line_scheduler #(.GAP(G), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT),
                         .CAM1_ID(5'd1), .CAM2_ID(5'd2)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .req(req), .row1(row1), .row2(row2),
        .grant(grant), .udp_trig(udp_trig), .udp_index(udp_index), .udp_busy(udp_busy),
        .timeout_err(timeout_err), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // sender model: busy rises s_d cycles after trig and stays high s_l cycles (mode 0),
    // never rises (mode 1) or is stuck high (mode 2)
    int s_mode = 0, s_dmin = 1, s_dmax = 1, s_lmin = 10, s_lmax = 10;
    int s_d = 0, s_l = 0, s_rise = -1, s_fall = -1;
    initial begin
        udp_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (udp_trig) begin
                s_d    = $urandom_range(s_dmax, s_dmin);
                s_l    = $urandom_range(s_lmax, s_lmin);
                s_rise = cyc + s_d;
                s_fall = s_rise + s_l;
            end
            case (s_mode)
                0:       udp_busy = (cyc >= s_rise) && (cyc < s_fall);
                1:       udp_busy = 1'b0;
                default: udp_busy = 1'b1;
            endcase
        end
    end

    int bad = 0, trig_cnt = 0, err_cnt = 0;
    logic prev_trig = 1'b0, prev_err = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if ((grant != 2'b00) != udp_trig) bad++;
            if (udp_trig && !(grant == 2'b01 || grant == 2'b10)) bad++;
            if (udp_trig && prev_trig) bad++;
            if (timeout_err && prev_err) bad++;
            if (udp_trig) trig_cnt++;
            if (timeout_err) err_cnt++;
            prev_trig = udp_trig;
            prev_err  = timeout_err;
        end
    end

    // reference model state
    bit          m_ptr = 1'b0;
    logic [15:0] m_pkt = 16'd0;
    int          m_err = 0;

    task automatic m_launch(output logic [1:0] g, output logic [15:0] ix);
        if (req == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
        else              g = req;
        ix    = (g == 2'b01) ? {5'd1, row1} : {5'd2, row2};
        m_ptr = (g == 2'b01);
    endtask

    task automatic wait_trig(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (udp_trig) begin at = cyc; break; end
        end
    endtask

    task automatic wait_err(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (timeout_err) begin at = cyc; break; end
        end
    endtask

    task automatic test_reset();
        logic [1:0] g; logic [15:0] ix;
        rstn = 1'b0; enable = 1'b1; req = 2'b11; row1 = 11'd5; row2 = 11'd7;
        s_mode = 0; s_dmin = 1; s_dmax = 1; s_lmin = 10; s_lmax = 10;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
        checks++; if (udp_trig !== 1'b0) begin errors++; $display("FAIL rst_trig got %b want 0", udp_trig); end
        checks++; if (udp_index !== 16'd0) begin errors++; $display("FAIL rst_index got %h want 0000", udp_index); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", timeout_err); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt got %0d want 0", pkt_cnt); end
        m_ptr = 1'b0; m_pkt = 16'd0;
        rstn = 1'b1;
        @(negedge clk);
        m_launch(g, ix);
        checks++; if (udp_trig !== 1'b1) begin errors++; $display("FAIL rst_first_trig got %b want 1", udp_trig); end
        checks++; if (grant !== g) begin errors++; $display("FAIL rst_first_grant got %b want %b", grant, g); end
        checks++; if (udp_index !== ix) begin errors++; $display("FAIL rst_first_index got %h want %h", udp_index, ix); end
        req = 2'b00;
        @(negedge clk);
        checks++; if ({grant, udp_trig} !== 3'b000) begin errors++; $display("FAIL pulse_width got %b want 000", {grant, udp_trig}); end
        repeat (120) @(negedge clk);
        m_pkt++;
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL rst_pkt_done got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_alternation();
        logic [1:0] g; logic [15:0] ix; int at, exp_at;
        s_mode = 0; s_dmin = 1; s_dmax = 4; s_lmin = 1; s_lmax = 20;
        row1 = 11'($urandom); row2 = 11'($urandom);
        req = 2'b11; exp_at = cyc + 1;
        ix = 16'd0;
        for (int k = 0; k < 6; k++) begin
            wait_trig(600, at);
            m_launch(g, ix);
            checks++; if (at != exp_at) begin errors++; $display("FAIL alt_time[%0d] got %0d want %0d", k, at, exp_at); end
            if (at < 0) break;
            checks++; if (grant !== g) begin errors++; $display("FAIL alt_grant[%0d] got %b want %b", k, grant, g); end
            checks++; if (udp_index !== ix) begin errors++; $display("FAIL alt_index[%0d] got %h want %h", k, udp_index, ix); end
            checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL alt_pkt[%0d] got %0d want %0d", k, pkt_cnt, m_pkt); end
            exp_at = at + s_d + s_l + 2 + G;
            m_pkt++;
            row1 = 11'($urandom); row2 = 11'($urandom);
        end
        req = 2'b00;
        repeat (150) @(negedge clk);
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL alt_pkt_end got %0d want %0d", pkt_cnt, m_pkt); end
        checks++; if (udp_index !== ix) begin errors++; $display("FAIL alt_index_hold got %h want %h", udp_index, ix); end
    endtask

    task automatic test_single();
        logic [1:0] g; logic [15:0] ix; int at;
        row1 = 11'($urandom); row2 = 11'($urandom);
        req = 2'b10;
        for (int k = 0; k < 4; k++) begin
            wait_trig(600, at);
            m_launch(g, ix);
            checks++; if (at < 0) begin errors++; $display("FAIL single_timeout[%0d] got none want trig", k); break; end
            checks++; if (grant !== g) begin errors++; $display("FAIL single_grant[%0d] got %b want %b", k, grant, g); end
            checks++; if (udp_index !== ix) begin errors++; $display("FAIL single_index[%0d] got %h want %h", k, udp_index, ix); end
            m_pkt++;
            if (k == 2) req = 2'b11;
        end
        req = 2'b00;
        repeat (150) @(negedge clk);
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL single_pkt got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_start_timeout();
        logic [1:0] g; logic [15:0] ix; int at, at2, e;
        s_mode = 1; req = 2'b01;
        wait_trig(50, at);
        m_launch(g, ix);
        checks++; if (grant !== g) begin errors++; $display("FAIL st_grant got %b want %b", grant, g); end
        wait_err(ST + 20, e); m_err++;
        checks++; if (e != at + ST) begin errors++; $display("FAIL st_err_time got %0d want %0d", e, at + ST); end
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL st_pkt got %0d want %0d", pkt_cnt, m_pkt); end
        wait_trig(G + 20, at2);
        m_launch(g, ix);
        checks++; if (at2 != at + ST + G + 1) begin errors++; $display("FAIL st_relaunch got %0d want %0d", at2, at + ST + G + 1); end
        checks++; if (udp_index !== ix) begin errors++; $display("FAIL st_index got %h want %h", udp_index, ix); end
        req = 2'b00;
        wait_err(ST + 20, e); m_err++;
        checks++; if (e != at2 + ST) begin errors++; $display("FAIL st_err2_time got %0d want %0d", e, at2 + ST); end
        repeat (G + 10) @(negedge clk);
    endtask

    task automatic test_done_timeout();
        logic [1:0] g; logic [15:0] ix; int at, e;
        s_mode = 2;
        repeat (2) @(negedge clk);
        req = 2'b01;
        wait_trig(50, at);
        m_launch(g, ix);
        req = 2'b00;
        wait_err(DT + 30, e); m_err++;
        checks++; if (e != at + 1 + DT) begin errors++; $display("FAIL dt_err_time got %0d want %0d", e, at + 1 + DT); end
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL dt_pkt got %0d want %0d", pkt_cnt, m_pkt); end
        repeat (G + 10) @(negedge clk);
        s_mode = 0; s_dmin = 1; s_dmax = 1; s_lmin = 5; s_lmax = 5;
        req = 2'b01;
        wait_trig(50, at);
        m_launch(g, ix);
        checks++; if (grant !== g) begin errors++; $display("FAIL dt_recover_grant got %b want %b", grant, g); end
        req = 2'b00; m_pkt++;
        repeat (G + 20) @(negedge clk);
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL dt_recover_pkt got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_enable();
        logic [1:0] g; logic [15:0] ix; int at, e, tc;
        s_mode = 0; s_dmin = 1; s_dmax = 1; s_lmin = 10; s_lmax = 10;
        row1 = 11'($urandom); row2 = 11'($urandom);
        req = 2'b11; enable = 1'b1;
        wait_trig(50, at);
        m_launch(g, ix);
        checks++; if (grant !== g) begin errors++; $display("FAIL en_grant got %b want %b", grant, g); end
        repeat (3) @(negedge clk);
        enable = 1'b0; m_pkt++; tc = trig_cnt;
        repeat (300) @(negedge clk);
        checks++; if (trig_cnt != tc) begin errors++; $display("FAIL en_hold got %0d trigs want %0d", trig_cnt, tc); end
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL en_pkt got %0d want %0d", pkt_cnt, m_pkt); end
        enable = 1'b1; e = cyc;
        wait_trig(5, at);
        m_launch(g, ix);
        checks++; if (at != e + 1) begin errors++; $display("FAIL en_latency got %0d want %0d", at, e + 1); end
        checks++; if (grant !== g) begin errors++; $display("FAIL en_grant2 got %b want %b", grant, g); end
        req = 2'b00; m_pkt++;
        repeat (150) @(negedge clk);
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL en_pkt2 got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_wrap();
        logic [1:0] g; logic [15:0] ix; int at;
        force dut.r_pkt_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        m_pkt = 16'hFFFF;
        req = 2'b10;
        wait_trig(50, at);
        m_launch(g, ix);
        req = 2'b00; m_pkt++;
        repeat (G + 40) @(negedge clk);
        checks++; if (pkt_cnt !== m_pkt) begin errors++; $display("FAIL wrap_pkt got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_pulses();
        checks++; if (bad != 0) begin errors++; $display("FAIL pulse_rules got %0d violations want 0", bad); end
        checks++; if (err_cnt != m_err) begin errors++; $display("FAIL err_count got %0d want %0d", err_cnt, m_err); end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; req = 2'b00; row1 = 11'd0; row2 = 11'd0;
        test_reset();
        test_alternation();
        test_single();
        test_start_timeout();
        test_done_timeout();
        test_enable();
        test_wrap();
        test_pulses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
